// File: rtl/debug_controller.sv
// Debug session sequencer: gates the core in step or continuous mode while the
// arbiter holds the debug grant, and hands each step/final dump to the dumper.
module debug_controller #(
  parameter logic [7:0]  CMD_STEP        = 8'h57,
  parameter logic [7:0]  CMD_ABORT       = 8'hAB,
  parameter logic [31:0] WATCHDOG_CYCLES = 32'd1048576
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        grant_i,
  input  logic        exec_mode_i,
  input  logic [7:0]  uart_rx_data_i,
  input  logic        uart_rx_ready_i,
  input  logic        core_halted_i,
  output logic        core_run_o,
  output logic        dump_start_o,
  output logic        dump_final_o,
  input  logic        dump_done_i,
  output logic        done_o,
  output logic        timeout_o,
  output logic [31:0] cycle_count_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_STEP_WAIT, S_STEP_EXEC, S_DUMP_TRIG, S_DUMP_WAIT, S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic        r_mode;
  logic        r_haltSeen;
  logic        r_final;
  logic        r_timeout;
  logic [31:0] r_cycleCount;
  logic        w_run;
  logic        w_grantLost;
  logic        w_wdHit;
  logic        w_rxStep;
  logic        w_rxAbort;
  logic        w_cntSat;

  assign w_grantLost = (r_state != S_IDLE) && !grant_i;
  assign w_wdHit     = (r_cycleCount == (WATCHDOG_CYCLES - 32'd1));
  assign w_rxStep    = uart_rx_ready_i && (uart_rx_data_i == CMD_STEP);
  assign w_rxAbort   = uart_rx_ready_i && (uart_rx_data_i == CMD_ABORT);
  assign w_cntSat    = (r_cycleCount == 32'hFFFF_FFFF);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (w_grantLost) begin
      w_nextState = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:      if (grant_i) w_nextState = exec_mode_i ? S_RUN : S_STEP_WAIT;
        S_RUN:       if (core_halted_i || w_wdHit) w_nextState = S_DUMP_TRIG;
        S_STEP_WAIT: begin
          if (w_rxStep)       w_nextState = S_STEP_EXEC;
          else if (w_rxAbort) w_nextState = S_DUMP_TRIG;
        end
        S_STEP_EXEC: w_nextState = S_DUMP_TRIG;
        S_DUMP_TRIG: w_nextState = S_DUMP_WAIT;
        S_DUMP_WAIT: begin
          if (dump_done_i)
            w_nextState = (r_final || r_haltSeen || r_mode) ? S_DONE : S_STEP_WAIT;
        end
        S_DONE:      w_nextState = S_DONE;
        default:     w_nextState = S_IDLE;
      endcase
    end
  end

  // Run enable is combinational so a retiring halt stops the core in the same cycle.
  always_comb begin
    w_run        = 1'b0;
    dump_start_o = 1'b0;
    dump_final_o = 1'b0;
    done_o       = 1'b0;
    case (r_state)
      S_RUN:       w_run = grant_i && !core_halted_i;
      S_STEP_EXEC: w_run = grant_i;
      S_DUMP_TRIG: begin
        dump_start_o = grant_i;
        dump_final_o = r_final;
      end
      S_DUMP_WAIT: dump_final_o = r_final;
      S_DONE:      done_o = 1'b1;
      default:     ;
    endcase
  end

  assign core_run_o    = w_run;
  assign timeout_o     = r_timeout;
  assign cycle_count_o = r_cycleCount;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mode       <= 1'b0;
      r_haltSeen   <= 1'b0;
      r_final      <= 1'b0;
      r_timeout    <= 1'b0;
      r_cycleCount <= 32'd0;
    end else if (w_grantLost) begin
      r_haltSeen   <= 1'b0;
      r_final      <= 1'b0;
      r_timeout    <= 1'b0;
      r_cycleCount <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (grant_i) begin
            r_mode       <= exec_mode_i;
            r_haltSeen   <= 1'b0;
            r_final      <= 1'b0;
            r_timeout    <= 1'b0;
            r_cycleCount <= 32'd0;
          end
        end
        S_RUN: begin
          if (w_run && !w_cntSat) r_cycleCount <= r_cycleCount + 32'd1;
          if (core_halted_i) begin
            r_haltSeen <= 1'b1;
            r_final    <= 1'b1;
          end else if (w_wdHit) begin
            r_timeout <= 1'b1;
            r_final   <= 1'b1;
          end
        end
        S_STEP_WAIT: begin
          if (w_rxAbort && !w_rxStep) r_final <= 1'b1;
        end
        S_STEP_EXEC: begin
          if (w_run && !w_cntSat) r_cycleCount <= r_cycleCount + 32'd1;
          if (core_halted_i) begin
            r_haltSeen <= 1'b1;
            r_final    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_controller.sv
// Randomized self-checking bench for debug_controller with a session-level
// reference model (expected run counts, final/timeout flags) per scenario.
module tb_debug_controller;

  localparam int         WD    = 16;
  localparam logic [7:0] STEP  = 8'h57;
  localparam logic [7:0] ABORT = 8'hAB;

  logic        clk = 1'b0;
  logic        rstN;
  logic        grant;
  logic        execMode;
  logic [7:0]  rxData;
  logic        rxReady;
  logic        coreHalted;
  logic        dumpDone;
  logic        coreRun;
  logic        dumpStart;
  logic        dumpFinal;
  logic        done;
  logic        timeout;
  logic [31:0] cycleCount;

  int checks = 0;
  int errors = 0;

  wire [36:0] allOut = {coreRun, dumpStart, dumpFinal, done, timeout, cycleCount};

  always #5 clk = ~clk;

  debug_controller #(
    .CMD_STEP(STEP),
    .CMD_ABORT(ABORT),
    .WATCHDOG_CYCLES(32'(WD))
  ) dut (
    .clk_i(clk),
    .rst_ni(rstN),
    .grant_i(grant),
    .exec_mode_i(execMode),
    .uart_rx_data_i(rxData),
    .uart_rx_ready_i(rxReady),
    .core_halted_i(coreHalted),
    .core_run_o(coreRun),
    .dump_start_o(dumpStart),
    .dump_final_o(dumpFinal),
    .dump_done_i(dumpDone),
    .done_o(done),
    .timeout_o(timeout),
    .cycle_count_o(cycleCount)
  );

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout got running expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic test_reset;
    rstN = 1'b0; grant = 1'b0; execMode = 1'b0; rxData = 8'h00;
    rxReady = 1'b0; coreHalted = 1'b0; dumpDone = 1'b0;
    #3;
    checks++;
    if (allOut !== 37'd0) begin
      errors++; $display("[TB] FAIL reset_outputs got %h expected 0", allOut);
    end
    grant = 1'b1; execMode = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (allOut !== 37'd0) begin
      errors++; $display("[TB] FAIL reset_held_with_grant got %h expected 0", allOut);
    end
    @(negedge clk); grant = 1'b0; execMode = 1'b0; rstN = 1'b1;
    @(negedge clk);
  endtask

  // haltAt: run cycle (1-based) on which the halt retires; 0 means never.
  task automatic test_continuous(input int haltAt);
    int expRuns; bit expTo; int runs; bit started;
    if (haltAt != 0 && haltAt <= WD) begin expRuns = haltAt - 1; expTo = 1'b0; end
    else begin expRuns = WD; expTo = 1'b1; end
    $display("[TB] continuous session haltAt=%0d", haltAt);
    @(negedge clk); grant = 1'b1; execMode = 1'b1; #1;
    checks++;
    if (coreRun !== 1'b0) begin
      errors++; $display("[TB] FAIL cont_idle_run got %b expected 0", coreRun);
    end
    runs = 0; started = 1'b0;
    for (int i = 1; i <= WD + 4 && !started; i++) begin
      @(negedge clk); coreHalted = (i == haltAt); #1;
      if (dumpStart === 1'b1) started = 1'b1;
      else begin
        checks++;
        if (coreRun !== (i <= expRuns)) begin
          errors++; $display("[TB] FAIL cont_run[%0d] got %b expected %b", i, coreRun, (i <= expRuns));
        end
        if (coreRun === 1'b1) runs++;
      end
    end
    coreHalted = 1'b0;
    checks++;
    if (!started) begin
      errors++; $display("[TB] FAIL cont_dump_start got 0 expected 1");
    end
    checks++;
    if (runs != expRuns) begin
      errors++; $display("[TB] FAIL cont_run_cycles got %0d expected %0d", runs, expRuns);
    end
    checks++;
    if (cycleCount !== 32'(expRuns)) begin
      errors++; $display("[TB] FAIL cont_cycle_count got %0d expected %0d", cycleCount, expRuns);
    end
    checks++;
    if (timeout !== expTo || dumpFinal !== 1'b1) begin
      errors++; $display("[TB] FAIL cont_flags got to=%b fin=%b expected to=%b fin=1", timeout, dumpFinal, expTo);
    end
    repeat ($urandom_range(0, 3)) begin
      @(negedge clk); #1;
      checks++;
      if (dumpStart !== 1'b0 || done !== 1'b0 || dumpFinal !== 1'b1) begin
        errors++; $display("[TB] FAIL cont_dump_wait got st=%b done=%b fin=%b expected 0 0 1", dumpStart, done, dumpFinal);
      end
    end
    @(negedge clk); dumpDone = 1'b1; #1;
    @(negedge clk); dumpDone = 1'b0; #1;
    checks++;
    if (done !== 1'b1 || timeout !== expTo || cycleCount !== 32'(expRuns)) begin
      errors++; $display("[TB] FAIL cont_done got done=%b to=%b cnt=%0d expected 1 %b %0d", done, timeout, cycleCount, expTo, expRuns);
    end
    repeat ($urandom_range(1, 3)) begin
      @(negedge clk); #1;
      checks++;
      if (done !== 1'b1 || coreRun !== 1'b0) begin
        errors++; $display("[TB] FAIL cont_done_hold got done=%b run=%b expected 1 0", done, coreRun);
      end
    end
    @(negedge clk); grant = 1'b0; #1;
    @(negedge clk); #1;
    checks++;
    if (allOut !== 37'd0) begin
      errors++; $display("[TB] FAIL cont_after_grant got %h expected 0", allOut);
    end
  endtask

  // haltOn: step number whose instruction is the halt; 0 means none.
  task automatic test_step(input int nSteps, input int haltOn, input bit doAbort, input bit junk);
    int runs; int expSteps; bit ended; logic [7:0] b;
    runs = 0; ended = 1'b0;
    expSteps = (haltOn >= 1 && haltOn <= nSteps) ? haltOn : nSteps;
    $display("[TB] step session n=%0d halt=%0d abort=%b junk=%b", nSteps, haltOn, doAbort, junk);
    @(negedge clk); grant = 1'b1; execMode = 1'b0; #1;
    @(negedge clk); dumpDone = 1'b1; #1;
    @(negedge clk); dumpDone = 1'b0; #1;
    checks++;
    if (coreRun !== 1'b0 || dumpStart !== 1'b0 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL step_stray_done got run=%b st=%b done=%b expected 0 0 0", coreRun, dumpStart, done);
    end
    for (int s = 1; s <= nSteps && !ended; s++) begin
      if (junk) begin
        do b = 8'($urandom); while (b == STEP || b == ABORT);
        @(negedge clk); rxReady = 1'b1; rxData = b; #1;
        @(negedge clk); rxReady = 1'b0; #1;
        checks++;
        if (coreRun !== 1'b0 || dumpStart !== 1'b0) begin
          errors++; $display("[TB] FAIL step_junk got run=%b st=%b expected 0 0", coreRun, dumpStart);
        end
      end
      @(negedge clk); rxReady = 1'b1; rxData = STEP; #1;
      @(negedge clk); rxReady = 1'b1; rxData = STEP; coreHalted = (s == haltOn); #1;
      checks++;
      if (coreRun !== 1'b1) begin
        errors++; $display("[TB] FAIL step_run[%0d] got %b expected 1", s, coreRun);
      end
      if (coreRun === 1'b1) runs++;
      @(negedge clk); rxReady = 1'b0; coreHalted = 1'b0; #1;
      checks++;
      if (dumpStart !== 1'b1 || coreRun !== 1'b0 || dumpFinal !== (s == haltOn)) begin
        errors++; $display("[TB] FAIL step_dump[%0d] got st=%b run=%b fin=%b expected 1 0 %b", s, dumpStart, coreRun, dumpFinal, (s == haltOn));
      end
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk); rxReady = 1'($urandom_range(0, 1)); rxData = STEP; #1;
        checks++;
        if (coreRun !== 1'b0 || dumpStart !== 1'b0 || done !== 1'b0) begin
          errors++; $display("[TB] FAIL step_dump_wait got run=%b st=%b done=%b expected 0 0 0", coreRun, dumpStart, done);
        end
      end
      @(negedge clk); rxReady = 1'b0; dumpDone = 1'b1; #1;
      @(negedge clk); dumpDone = 1'b0; #1;
      checks++;
      if (done !== (s == haltOn) || coreRun !== 1'b0) begin
        errors++; $display("[TB] FAIL step_after_dump[%0d] got done=%b run=%b expected %b 0", s, done, coreRun, (s == haltOn));
      end
      if (s == haltOn) ended = 1'b1;
    end
    if (!ended && doAbort) begin
      @(negedge clk); rxReady = 1'b1; rxData = 8'h00; #1;
      @(negedge clk); rxReady = 1'b1; rxData = ABORT; #1;
      checks++;
      if (coreRun !== 1'b0 || dumpStart !== 1'b0) begin
        errors++; $display("[TB] FAIL abort_junk got run=%b st=%b expected 0 0", coreRun, dumpStart);
      end
      @(negedge clk); rxReady = 1'b0; #1;
      checks++;
      if (dumpStart !== 1'b1 || dumpFinal !== 1'b1 || coreRun !== 1'b0) begin
        errors++; $display("[TB] FAIL abort_dump got st=%b fin=%b run=%b expected 1 1 0", dumpStart, dumpFinal, coreRun);
      end
      @(negedge clk); dumpDone = 1'b1; #1;
      @(negedge clk); dumpDone = 1'b0; #1;
      ended = 1'b1;
    end
    checks++;
    if (runs != expSteps || cycleCount !== 32'(expSteps)) begin
      errors++; $display("[TB] FAIL step_count got runs=%0d cnt=%0d expected %0d", runs, cycleCount, expSteps);
    end
    checks++;
    if (done !== ended || timeout !== 1'b0) begin
      errors++; $display("[TB] FAIL step_end got done=%b to=%b expected %b 0", done, timeout, ended);
    end
    @(negedge clk); grant = 1'b0; #1;
    @(negedge clk); #1;
    checks++;
    if (allOut !== 37'd0) begin
      errors++; $display("[TB] FAIL step_after_grant got %h expected 0", allOut);
    end
  endtask

  task automatic test_grant_drop;
    bit started;
    started = 1'b0;
    @(negedge clk); grant = 1'b1; execMode = 1'b1; #1;
    for (int i = 0; i < WD + 4 && !started; i++) begin
      @(negedge clk); #1;
      if (dumpStart === 1'b1) started = 1'b1;
    end
    @(negedge clk); #1;
    checks++;
    if (!started || timeout !== 1'b1 || cycleCount !== 32'(WD) || dumpFinal !== 1'b1) begin
      errors++; $display("[TB] FAIL drop_pre got seen=%b to=%b cnt=%0d fin=%b expected 1 1 %0d 1", started, timeout, cycleCount, dumpFinal, WD);
    end
    @(negedge clk); grant = 1'b0; #1;
    checks++;
    if (coreRun !== 1'b0 || dumpStart !== 1'b0) begin
      errors++; $display("[TB] FAIL drop_gate got run=%b st=%b expected 0 0", coreRun, dumpStart);
    end
    @(negedge clk); #1;
    checks++;
    if (allOut !== 37'd0) begin
      errors++; $display("[TB] FAIL drop_idle got %h expected 0", allOut);
    end
    @(negedge clk); grant = 1'b1; execMode = 1'b1; #1;
    @(negedge clk); #1;
    checks++;
    if (coreRun !== 1'b1 || cycleCount !== 32'd0 || timeout !== 1'b0) begin
      errors++; $display("[TB] FAIL drop_restart got run=%b cnt=%0d to=%b expected 1 0 0", coreRun, cycleCount, timeout);
    end
    @(negedge clk); grant = 1'b0; #1;
    @(negedge clk); #1;
    checks++;
    if (allOut !== 37'd0) begin
      errors++; $display("[TB] FAIL drop_restart_idle got %h expected 0", allOut);
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk); grant = 1'b1; execMode = 1'b1; #1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (coreRun !== 1'b1 || cycleCount !== 32'd2) begin
      errors++; $display("[TB] FAIL areset_pre got run=%b cnt=%0d expected 1 2", coreRun, cycleCount);
    end
    #1 rstN = 1'b0;
    #1;
    checks++;
    if (allOut !== 37'd0) begin
      errors++; $display("[TB] FAIL areset_immediate got %h expected 0", allOut);
    end
    @(negedge clk); grant = 1'b0; execMode = 1'b0;
    @(negedge clk); rstN = 1'b1; #1;
    checks++;
    if (allOut !== 37'd0) begin
      errors++; $display("[TB] FAIL areset_release got %h expected 0", allOut);
    end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 5; k++) begin
      if ($urandom_range(0, 1) == 1)
        test_continuous(int'($urandom_range(1, WD + 2)));
      else
        test_step(int'($urandom_range(1, 4)), int'($urandom_range(0, 4)),
                  1'($urandom_range(0, 1)), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_continuous(10);
    test_continuous(int'($urandom_range(1, WD)));
    test_continuous(0);
    test_continuous(WD);
    test_step(3, 0, 1'b0, 1'b0);
    test_step(0, 0, 1'b1, 1'b0);
    test_step(4, 2, 1'b0, 1'b1);
    test_step(2, 0, 1'b1, 1'b1);
    test_grant_drop();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
